rs_age_station: RTL and testbench

//  Next-generation reservation station: parametrised depth, tag width and CDB count.

---
 rtl/rs_age_station.sv | 155 +++++++++++++++
 tb/tb_rs_age_station.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_age_station.sv
// rs_age_station: reservation station with CDB wakeup, age-matrix oldest-first
// select and ROB-relative flush squash, feeding a single execution pipe.
module rs_age_station #(
  parameter int NUM_SLOTS = 8,
  parameter int PTAG_W    = 6,
  parameter int ROB_W     = 5,
  parameter int NUM_CDB   = 2,
  parameter int PAYLOAD_W = 96
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              disp_valid,
  input  logic [PAYLOAD_W-1:0]              disp_payload,
  input  logic [PTAG_W-1:0]                 disp_src1,
  input  logic [PTAG_W-1:0]                 disp_src2,
  input  logic                              disp_src1_rdy,
  input  logic                              disp_src2_rdy,
  input  logic                              disp_use_src2,
  input  logic [ROB_W-1:0]                  disp_rob,
  output logic                              full,
  output logic [$clog2(NUM_SLOTS+1)-1:0]    count,
  input  logic [NUM_CDB-1:0]                cdb_valid,
  input  logic [NUM_CDB*PTAG_W-1:0]         cdb_tag,
  input  logic                              flush_valid,
  input  logic [ROB_W-1:0]                  flush_rob,
  input  logic [ROB_W-1:0]                  rob_head,
  output logic                              issue_valid,
  input  logic                              issue_ready,
  output logic [PAYLOAD_W-1:0]              issue_payload,
  output logic [PTAG_W-1:0]                 issue_src1,
  output logic [PTAG_W-1:0]                 issue_src2,
  output logic [ROB_W-1:0]                  issue_rob
);
  localparam int IDX_W = $clog2(NUM_SLOTS);
  localparam int CNT_W = $clog2(NUM_SLOTS + 1);

  logic [NUM_SLOTS-1:0] valid_q, src1_rdy_q, src2_rdy_q;
  logic [NUM_SLOTS-1:0] age_q [NUM_SLOTS];
  logic [PAYLOAD_W-1:0] payload_q [NUM_SLOTS];
  logic [PTAG_W-1:0]    src1_q [NUM_SLOTS];
  logic [PTAG_W-1:0]    src2_q [NUM_SLOTS];
  logic [ROB_W-1:0]     rob_q [NUM_SLOTS];

  logic [NUM_SLOTS-1:0] wake1, wake2, runnable, blocked, sel_oh, kill;
  logic [ROB_W-1:0]     rob_dist [NUM_SLOTS];
  logic [ROB_W-1:0]     flush_dist;
  logic [IDX_W-1:0]     alloc_idx;
  logic                 alloc_en, issue_fire, disp_hit1, disp_hit2;
  logic                 init1, init2;

  // Handshake: issue_valid is offered from registered state regardless of
  // issue_ready; the op leaves on the edge where both are high. Dispatch has
  // no ready of its own -- the producer must honour full.
  always_comb begin
    full  = &valid_q;
    count = '0;
    for (int i = 0; i < NUM_SLOTS; i++) count = count + CNT_W'(valid_q[i]);
  end

  always_comb begin
    alloc_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--)
      if (!valid_q[i]) alloc_idx = IDX_W'(i);
  end

  assign alloc_en = disp_valid && !full && !flush_valid;

  always_comb begin
    disp_hit1 = 1'b0;
    disp_hit2 = 1'b0;
    wake1     = '0;
    wake2     = '0;
    for (int k = 0; k < NUM_CDB; k++) begin
      if (cdb_valid[k] && cdb_tag[k*PTAG_W +: PTAG_W] == disp_src1) disp_hit1 = 1'b1;
      if (cdb_valid[k] && cdb_tag[k*PTAG_W +: PTAG_W] == disp_src2) disp_hit2 = 1'b1;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (valid_q[i] && cdb_valid[k] && cdb_tag[k*PTAG_W +: PTAG_W] == src1_q[i]) wake1[i] = 1'b1;
        if (valid_q[i] && cdb_valid[k] && cdb_tag[k*PTAG_W +: PTAG_W] == src2_q[i]) wake2[i] = 1'b1;
      end
    end
  end

  assign init1 = disp_src1_rdy || (disp_src1 == '0) || disp_hit1;
  assign init2 = !disp_use_src2 || disp_src2_rdy || (disp_src2 == '0) || disp_hit2;

  assign runnable = valid_q & src1_rdy_q & src2_rdy_q;

  // A runnable entry is blocked if any other runnable entry is older than it.
  always_comb begin
    blocked = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      for (int j = 0; j < NUM_SLOTS; j++)
        if (runnable[j] && age_q[j][i]) blocked[i] = 1'b1;
  end

  assign sel_oh      = runnable & ~blocked;
  assign issue_valid = (|sel_oh) && !flush_valid;
  assign issue_fire  = issue_valid && issue_ready;

  always_comb begin
    issue_payload = '0;
    issue_src1    = '0;
    issue_src2    = '0;
    issue_rob     = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      issue_payload = issue_payload | ({PAYLOAD_W{sel_oh[i]}} & payload_q[i]);
      issue_src1    = issue_src1    | ({PTAG_W{sel_oh[i]}}    & src1_q[i]);
      issue_src2    = issue_src2    | ({PTAG_W{sel_oh[i]}}    & src2_q[i]);
      issue_rob     = issue_rob     | ({ROB_W{sel_oh[i]}}     & rob_q[i]);
    end
  end

  // Younger than the mispredicted branch, measured from the ROB head.
  assign flush_dist = flush_rob - rob_head;
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      rob_dist[i] = rob_q[i] - rob_head;
      kill[i]     = valid_q[i] && (rob_dist[i] > flush_dist);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q    <= '0;
      src1_rdy_q <= '0;
      src2_rdy_q <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (wake1[i]) src1_rdy_q[i] <= 1'b1;
        if (wake2[i]) src2_rdy_q[i] <= 1'b1;
        if ((flush_valid && kill[i]) || (issue_fire && sel_oh[i])) valid_q[i] <= 1'b0;
      end
      if (alloc_en) begin
        valid_q[alloc_idx]    <= 1'b1;
        src1_rdy_q[alloc_idx] <= init1;
        src2_rdy_q[alloc_idx] <= init2;
        for (int j = 0; j < NUM_SLOTS; j++) begin
          age_q[j][alloc_idx] <= valid_q[j];
          age_q[alloc_idx][j] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_en) begin
      payload_q[alloc_idx] <= disp_payload;
      src1_q[alloc_idx]    <= disp_src1;
      src2_q[alloc_idx]    <= disp_src2;
      rob_q[alloc_idx]     <= disp_rob;
    end
  end

endmodule

// File: tb/tb_rs_age_station.sv
// Bench for rs_age_station: directed scenarios checked every cycle against an
// age-ordered queue model, plus literal spot checks and an issue-order scoreboard.
module tb_rs_age_station;
  localparam int NUM_SLOTS = 8;
  localparam int PTAG_W    = 6;
  localparam int ROB_W     = 5;
  localparam int NUM_CDB   = 2;
  localparam int PAYLOAD_W = 96;

  typedef struct {
    logic [PAYLOAD_W-1:0] payload;
    logic [PTAG_W-1:0]    s1;
    logic [PTAG_W-1:0]    s2;
    bit                   r1;
    bit                   r2;
    logic [ROB_W-1:0]     rob;
  } ent_t;

  logic                           clk = 1'b0;
  logic                           reset;
  logic                           disp_valid;
  logic [PAYLOAD_W-1:0]           disp_payload;
  logic [PTAG_W-1:0]              disp_src1, disp_src2;
  logic                           disp_src1_rdy, disp_src2_rdy, disp_use_src2;
  logic [ROB_W-1:0]               disp_rob;
  logic                           full;
  logic [$clog2(NUM_SLOTS+1)-1:0] count;
  logic [NUM_CDB-1:0]             cdb_valid;
  logic [NUM_CDB*PTAG_W-1:0]      cdb_tag;
  logic                           flush_valid;
  logic [ROB_W-1:0]               flush_rob, rob_head;
  logic                           issue_valid, issue_ready;
  logic [PAYLOAD_W-1:0]           issue_payload;
  logic [PTAG_W-1:0]              issue_src1, issue_src2;
  logic [ROB_W-1:0]               issue_rob;

  ent_t             mq[$];     // model: valid entries, oldest first
  logic [ROB_W-1:0] exp_q[$];  // expected issue order (ROB tags)
  int n_tests = 0;
  int n_fail  = 0;

  rs_age_station #(
    .NUM_SLOTS(NUM_SLOTS), .PTAG_W(PTAG_W), .ROB_W(ROB_W),
    .NUM_CDB(NUM_CDB), .PAYLOAD_W(PAYLOAD_W)
  ) dut (
    .clk(clk), .reset(reset),
    .disp_valid(disp_valid), .disp_payload(disp_payload),
    .disp_src1(disp_src1), .disp_src2(disp_src2),
    .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
    .disp_use_src2(disp_use_src2), .disp_rob(disp_rob),
    .full(full), .count(count),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .flush_valid(flush_valid), .flush_rob(flush_rob), .rob_head(rob_head),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_payload(issue_payload), .issue_src1(issue_src1),
    .issue_src2(issue_src2), .issue_rob(issue_rob)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  // ---------------- model helpers ----------------
  function automatic bit cdb_hit(input logic [PTAG_W-1:0] t);
    for (int k = 0; k < NUM_CDB; k++)
      if (cdb_valid[k] && cdb_tag[k*PTAG_W +: PTAG_W] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int oldest_runnable();
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].r1 && mq[i].r2) return i;
    return -1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model state advances on each rising edge from the inputs held across it.
  always @(posedge clk) begin
    if (reset) begin
      int sel;
      bit full_now;
      logic [ROB_W-1:0] fd, d;
      ent_t e;
      full_now = (mq.size() == NUM_SLOTS);
      sel = oldest_runnable();
      if (flush_valid) begin
        fd = flush_rob - rob_head;
        for (int i = mq.size() - 1; i >= 0; i--) begin
          d = mq[i].rob - rob_head;
          if (d > fd) mq.delete(i);
        end
      end else if (sel >= 0 && issue_ready) begin
        mq.delete(sel);
      end
      for (int i = 0; i < mq.size(); i++) begin
        if (cdb_hit(mq[i].s1)) mq[i].r1 = 1'b1;
        if (cdb_hit(mq[i].s2)) mq[i].r2 = 1'b1;
      end
      if (disp_valid && !full_now && !flush_valid) begin
        e.payload = disp_payload;
        e.s1      = disp_src1;
        e.s2      = disp_src2;
        e.rob     = disp_rob;
        e.r1      = disp_src1_rdy || (disp_src1 == '0) || cdb_hit(disp_src1);
        e.r2      = !disp_use_src2 || disp_src2_rdy || (disp_src2 == '0) || cdb_hit(disp_src2);
        mq.push_back(e);
      end
    end
  end

  // ---------------- compare + scoreboard (falling edge) ----------------
  always @(negedge clk) begin
    if (reset) begin
      int sel;
      bit exp_iv;
      sel = oldest_runnable();
      exp_iv = (sel >= 0) && !flush_valid;
      chk("count", int'(count), mq.size());
      chk("full", int'(full), int'(mq.size() == NUM_SLOTS));
      chk("issue_valid", int'(issue_valid), int'(exp_iv));
      if (exp_iv) begin
        chk("issue_rob", int'(issue_rob), int'(mq[sel].rob));
        chk("issue_src1", int'(issue_src1), int'(mq[sel].s1));
        chk("issue_src2", int'(issue_src2), int'(mq[sel].s2));
        n_tests++;
        if (issue_payload !== mq[sel].payload) begin
          n_fail++;
          $display("FAIL issue_payload: got %h expected %h", issue_payload, mq[sel].payload);
        end
      end
      if (issue_valid && issue_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL issue_order: got issue of rob %0d expected no issue", issue_rob);
        end else begin
          chk("issue_order", int'(issue_rob), int'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input int rob, input int s1, input bit r1,
                          input int s2, input bit r2, input bit use2);
    disp_valid    = 1'b1;
    disp_rob      = ROB_W'(rob);
    disp_src1     = PTAG_W'(s1);
    disp_src1_rdy = r1;
    disp_src2     = PTAG_W'(s2);
    disp_src2_rdy = r2;
    disp_use_src2 = use2;
    disp_payload  = {$urandom(), $urandom(), $urandom()};
    tick();
    disp_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    issue_ready = 1'b1;
    repeat (n) tick();
    issue_ready = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b0;
    disp_valid = 1'b0; disp_payload = '0; disp_src1 = '0; disp_src2 = '0;
    disp_src1_rdy = 1'b0; disp_src2_rdy = 1'b0; disp_use_src2 = 1'b0; disp_rob = '0;
    cdb_valid = '0; cdb_tag = '0; flush_valid = 1'b0; flush_rob = '0; rob_head = '0;
    issue_ready = 1'b0;

    repeat (2) tick();
    chk("reset_count", int'(count), 0);
    chk("reset_full", int'(full), 0);
    chk("reset_issue_valid", int'(issue_valid), 0);
    reset = 1'b1;
    tick();

    // Fill every slot; extra dispatch while full is dropped.
    for (int i = 0; i < NUM_SLOTS; i++) dispatch(i, 1 + i, 1'b1, 0, 1'b0, 1'b1);
    chk("t1_full", int'(full), 1);
    chk("t1_count", int'(count), 8);
    chk("t1_issue_rob", int'(issue_rob), 0);
    dispatch(8, 9, 1'b1, 0, 1'b0, 1'b1);
    chk("t1_count_after_full_disp", int'(count), 8);
    for (int i = 0; i < NUM_SLOTS; i++) exp_q.push_back(ROB_W'(i));
    drain(NUM_SLOTS);
    chk("t1_drained", int'(count), 0);

    // Age beats index: A lands in slot 5, B later in slot 0.
    for (int i = 0; i < 5; i++) dispatch(10 + i, 40 + i, 1'b0, 0, 1'b0, 1'b0);
    dispatch(3, 1, 1'b1, 2, 1'b1, 1'b1);
    cdb_valid = 2'b01; cdb_tag = {6'd0, 6'd40};
    tick();
    cdb_valid = '0;
    exp_q.push_back(5'd10);
    drain(1);
    dispatch(4, 1, 1'b1, 2, 1'b1, 1'b1);
    chk("t2_oldest_first", int'(issue_rob), 3);
    exp_q.push_back(5'd3); exp_q.push_back(5'd4);
    drain(2);
    cdb_valid = 2'b11; cdb_tag = {6'd42, 6'd41};
    tick();
    cdb_tag = {6'd44, 6'd43};
    tick();
    cdb_valid = '0;
    for (int i = 11; i <= 14; i++) exp_q.push_back(ROB_W'(i));
    drain(4);
    chk("t2_drained", int'(count), 0);

    // Dual-bus wakeup: eligible exactly one cycle after the broadcast.
    dispatch(20, 17, 1'b0, 22, 1'b0, 1'b1);
    cdb_valid = 2'b11; cdb_tag = {6'd22, 6'd17};
    #1;
    chk("t3_not_yet", int'(issue_valid), 0);
    tick();
    cdb_valid = '0;
    chk("t3_woken", int'(issue_valid), 1);
    chk("t3_rob", int'(issue_rob), 20);
    exp_q.push_back(5'd20);
    drain(1);

    // Dispatch-time CDB capture, tag-0 sources, and a still-waiting entry.
    cdb_valid = 2'b10; cdb_tag = {6'd9, 6'd5};
    dispatch(21, 9, 1'b0, 0, 1'b0, 1'b0);
    cdb_valid = '0;
    chk("t4_ready_at_alloc", int'(issue_valid), 1);
    chk("t4_rob", int'(issue_rob), 21);
    dispatch(22, 0, 1'b0, 0, 1'b0, 1'b1);
    dispatch(23, 33, 1'b0, 0, 1'b0, 1'b0);
    chk("t4_count", int'(count), 3);
    exp_q.push_back(5'd21); exp_q.push_back(5'd22);
    drain(3);
    chk("t4_waiter_left", int'(count), 1);
    chk("t4_waiter_idle", int'(issue_valid), 0);
    cdb_valid = 2'b10; cdb_tag = {6'd33, 6'd0};
    tick();
    cdb_valid = '0;
    exp_q.push_back(5'd23);
    drain(1);

    // Flush across ROB wrap; wakeup still applies to the survivor.
    rob_head = 5'd30;
    dispatch(30, 1, 1'b1, 0, 1'b0, 1'b1);
    dispatch(31, 50, 1'b0, 0, 1'b0, 1'b1);
    dispatch(0, 1, 1'b1, 0, 1'b0, 1'b1);
    dispatch(1, 51, 1'b0, 0, 1'b0, 1'b1);
    chk("t5_count_before", int'(count), 4);
    flush_valid = 1'b1; flush_rob = 5'd31; issue_ready = 1'b1;
    cdb_valid = 2'b11; cdb_tag = {6'd51, 6'd50};
    disp_valid = 1'b1; disp_rob = 5'd2; disp_src1 = 6'd1; disp_src1_rdy = 1'b1;
    disp_src2 = 6'd0; disp_use_src2 = 1'b1;
    #1;
    chk("t5_no_issue_in_flush", int'(issue_valid), 0);
    tick();
    flush_valid = 1'b0; cdb_valid = '0; disp_valid = 1'b0; issue_ready = 1'b0;
    chk("t5_count_after", int'(count), 2);
    chk("t5_head_survives", int'(issue_rob), 30);
    exp_q.push_back(5'd30); exp_q.push_back(5'd31);
    drain(2);
    chk("t5_drained", int'(count), 0);
    rob_head = '0;

    // Asynchronous reset mid-stream, between clock edges.
    for (int i = 0; i < NUM_SLOTS; i++) dispatch(i, 1 + i, 1'b1, 0, 1'b0, 1'b1);
    chk("t6_full_before", int'(full), 1);
    #2;
    reset = 1'b0;
    mq.delete();
    #1;
    chk("t6_issue_valid", int'(issue_valid), 0);
    chk("t6_full", int'(full), 0);
    chk("t6_count", int'(count), 0);
    issue_ready = 1'b1;
    @(negedge clk);
    #2;
    reset = 1'b1;
    tick();
    chk("t6_post_count", int'(count), 0);
    chk("t6_post_issue_valid", int'(issue_valid), 0);
    tick();
    issue_ready = 1'b0;

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
